// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer owning the program counter
//
// Purpose: drives a req/ack handshake to instruction memory, applies branch
// redirects with delay-slot semantics, generates the pipeline stall vector and
// delivers fetched instructions to the IF/ID boundary.
//
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   stall_req_id, stall_req_ex  stall requests from ID / EX
//   branch_flag_i               taken branch resolved in ID
//   branch_target_address_i     branch target
//   inst_ack_i, inst_data_i     imem acknowledge and read data
//   pc, ce, inst_req_o          fetch address, imem enable, fetch request
//   inst_o, inst_valid_o        instruction to IF/ID and its one-cycle valid
//   stall                       {wb,mem,ex,id,if,pc} stall vector (combinational)
//   flush                       pipeline flush pulse
//   excp_flag_i, excp_epc_o     exception request / abandoned fetch pc
//
// Optional feature macro: FETCH_EXCP_EN (exception redirect, DRAIN state,
// excp_flag_i / excp_epc_o ports). Without it flush is tied low.

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] EXCP_VECTOR = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_req_id,
  input  logic        stall_req_ex,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  input  logic        inst_ack_i,
  input  logic [31:0] inst_data_i,
  output logic [31:0] pc,
  output logic        ce,
  output logic        inst_req_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic [5:0]  stall,
  output logic        flush
`ifdef FETCH_EXCP_EN
  ,
  input  logic        excp_flag_i,
  output logic [31:0] excp_epc_o
`endif
);

`ifdef FETCH_EXCP_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;
`endif

  state_t      state_q;
  logic [31:0] pc_q;
  logic        ce_q;
  logic        inst_req_q;
  logic [31:0] inst_q;
  logic        inst_valid_q;
  logic [31:0] hold_data_q;
  logic        pend_q;
  logic [31:0] pend_tgt_q;

  logic        if_stalled;
  logic        branch_take;
  logic [31:0] pc_plus4;
  logic [31:0] pc_d;

  // EX stall freezes everything up to and including EX; ID stall up to ID.
  always_comb begin
    stall = 6'b000000;
    if (stall_req_ex) begin
      stall = 6'b001111;
    end else if (stall_req_id) begin
      stall = 6'b000111;
    end
  end

  assign if_stalled  = stall[1];
  // A branch seen while ID is stalled is not yet resolved, so it is ignored.
  assign branch_take = branch_flag_i & ~stall[2];
  assign pc_plus4    = pc_q + 32'd4;

  // Pending redirect has priority: it belongs to the branch whose delay slot
  // is the instruction being completed now.
  always_comb begin
    pc_d = pc_plus4;
    if (pend_q) begin
      pc_d = pend_tgt_q;
    end else if (branch_take) begin
      pc_d = branch_target_address_i;
    end
  end

`ifdef FETCH_EXCP_EN
  logic        flush_q;
  logic [31:0] epc_q;
  logic        excp_take;

  // DRAIN already carries an exception; IDLE has nothing to abandon.
  assign excp_take = excp_flag_i && (state_q == FETCH || state_q == HOLD);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      ce_q         <= 1'b0;
      inst_req_q   <= 1'b0;
      inst_q       <= 32'h0;
      inst_valid_q <= 1'b0;
      hold_data_q  <= 32'h0;
      pend_q       <= 1'b0;
      pend_tgt_q   <= 32'h0;
`ifdef FETCH_EXCP_EN
      flush_q      <= 1'b0;
      epc_q        <= 32'h0;
`endif
    end else begin
      inst_valid_q <= 1'b0;
`ifdef FETCH_EXCP_EN
      flush_q      <= 1'b0;
      if (excp_take) begin
        flush_q <= 1'b1;
        epc_q   <= pc_q;
        pend_q  <= 1'b0;
        if (state_q == FETCH && !inst_ack_i) begin
          // Request cannot be withdrawn: wait for its ack, then discard it.
          state_q <= DRAIN;
        end else begin
          pc_q       <= EXCP_VECTOR;
          inst_req_q <= 1'b1;
          state_q    <= FETCH;
        end
      end else
`endif
      begin
        case (state_q)
          IDLE: begin
            ce_q       <= 1'b1;
            inst_req_q <= 1'b1;
            state_q    <= FETCH;
          end
          FETCH: begin
            if (inst_ack_i) begin
              if (!if_stalled) begin
                inst_q       <= inst_data_i;
                inst_valid_q <= 1'b1;
                pc_q         <= pc_d;
                pend_q       <= 1'b0;
              end else begin
                hold_data_q <= inst_data_i;
                inst_req_q  <= 1'b0;
                state_q     <= HOLD;
              end
            end else if (branch_take) begin
              // In-flight fetch is the delay slot; redirect after it lands.
              pend_q     <= 1'b1;
              pend_tgt_q <= branch_target_address_i;
            end
          end
          HOLD: begin
            if (!if_stalled) begin
              inst_q       <= hold_data_q;
              inst_valid_q <= 1'b1;
              pc_q         <= pc_d;
              pend_q       <= 1'b0;
              inst_req_q   <= 1'b1;
              state_q      <= FETCH;
            end else if (branch_take) begin
              pend_q     <= 1'b1;
              pend_tgt_q <= branch_target_address_i;
            end
          end
`ifdef FETCH_EXCP_EN
          DRAIN: begin
            if (inst_ack_i) begin
              pc_q    <= EXCP_VECTOR;
              state_q <= FETCH;
            end
          end
`endif
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign pc           = pc_q;
  assign ce           = ce_q;
  assign inst_req_o   = inst_req_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = inst_valid_q;

`ifdef FETCH_EXCP_EN
  assign flush      = flush_q;
  assign excp_epc_o = epc_q;
`else
  logic unused_excp_vector;
  assign unused_excp_vector = ^EXCP_VECTOR;
  assign flush              = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl

module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall_req_id;
  logic        stall_req_ex;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        inst_ack_i;
  logic [31:0] inst_data_i;
  logic [31:0] pc;
  logic        ce;
  logic        inst_req_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic [5:0]  stall;
  logic        flush;
`ifdef FETCH_EXCP_EN
  logic        excp_flag_i;
  logic [31:0] excp_epc_o;
`endif

  int checks = 0;
  int errors = 0;

  fetch_ctrl dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall_req_id            (stall_req_id),
    .stall_req_ex            (stall_req_ex),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .inst_ack_i              (inst_ack_i),
    .inst_data_i             (inst_data_i),
    .pc                      (pc),
    .ce                      (ce),
    .inst_req_o              (inst_req_o),
    .inst_o                  (inst_o),
    .inst_valid_o            (inst_valid_o),
    .stall                   (stall),
    .flush                   (flush)
`ifdef FETCH_EXCP_EN
    ,
    .excp_flag_i             (excp_flag_i),
    .excp_epc_o              (excp_epc_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    stall_req_id = 1'b0;
    stall_req_ex = 1'b0;
    branch_flag_i = 1'b0;
    branch_target_address_i = 32'h0;
    inst_ack_i = 1'b1;
    inst_data_i = 32'hDEAD_BEEF;
`ifdef FETCH_EXCP_EN
    excp_flag_i = 1'b0;
`endif
    tick();
    tick();
    check("rst_pc", pc, 32'h0);
    check("rst_ce", {31'h0, ce}, 32'h0);
    check("rst_req", {31'h0, inst_req_o}, 32'h0);
    check("rst_valid", {31'h0, inst_valid_o}, 32'h0);
    check("rst_inst", inst_o, 32'h0);
    check("rst_flush", {31'h0, flush}, 32'h0);
    check("rst_stall", {26'h0, stall}, 32'h0);

    // Reset release: IDLE -> FETCH, ce/req rise one cycle later.
    rst = 1'b1;
    inst_ack_i = 1'b0;
    tick();
    check("rel_ce", {31'h0, ce}, 32'h1);
    check("rel_req", {31'h0, inst_req_o}, 32'h1);
    check("rel_pc", pc, 32'h0);
    check("rel_valid", {31'h0, inst_valid_o}, 32'h0);

    // Back-to-back acks: 0x0, 0x4, 0x8.
    inst_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inst_data_i = 32'hA000_0000 + 32'(i * 4);
      tick();
      check("seq_valid", {31'h0, inst_valid_o}, 32'h1);
      check("seq_inst", inst_o, 32'hA000_0000 + 32'(i * 4));
      check("seq_pc", pc, 32'(i * 4 + 4));
    end

    // Three wait states at pc 0xC.
    inst_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_pc", pc, 32'hC);
      check("wait_req", {31'h0, inst_req_o}, 32'h1);
      check("wait_valid", {31'h0, inst_valid_o}, 32'h0);
    end
    inst_ack_i = 1'b1;
    inst_data_i = 32'hA000_000C;
    tick();
    check("wait_ack_valid", {31'h0, inst_valid_o}, 32'h1);
    check("wait_ack_inst", inst_o, 32'hA000_000C);
    check("wait_ack_pc", pc, 32'h10);
    inst_ack_i = 1'b0;
    tick();
    check("wait_single_pulse", {31'h0, inst_valid_o}, 32'h0);

    // Advance to 0x20.
    inst_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst_data_i = 32'hA000_0010 + 32'(i * 4);
      tick();
    end
    check("pre_br_pc", pc, 32'h20);

    // Branch while delay slot 0x20 is in flight.
    inst_ack_i = 1'b0;
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h100;
    tick();
    check("br_hold_pc", pc, 32'h20);
    check("br_no_valid", {31'h0, inst_valid_o}, 32'h0);
    branch_flag_i = 1'b0;
    branch_target_address_i = 32'h0;
    inst_ack_i = 1'b1;
    inst_data_i = 32'hB000_0020;
    tick();
    check("br_slot_valid", {31'h0, inst_valid_o}, 32'h1);
    check("br_slot_inst", inst_o, 32'hB000_0020);
    check("br_target_pc", pc, 32'h100);
    check("br_flush", {31'h0, flush}, 32'h0);

    // Stall vector encoding.
    inst_ack_i = 1'b0;
    stall_req_id = 1'b1;
    #1;
    check("stall_id", {26'h0, stall}, 32'h07);
    stall_req_ex = 1'b1;
    #1;
    check("stall_both", {26'h0, stall}, 32'h0F);
    stall_req_id = 1'b0;
    #1;
    check("stall_ex", {26'h0, stall}, 32'h0F);

    // EX stall for 4 cycles, ack arrives in the second.
    tick();
    check("st1_valid", {31'h0, inst_valid_o}, 32'h0);
    inst_ack_i = 1'b1;
    inst_data_i = 32'hC000_0100;
    tick();
    check("st2_valid", {31'h0, inst_valid_o}, 32'h0);
    check("st2_req", {31'h0, inst_req_o}, 32'h0);
    check("st2_pc", pc, 32'h100);
    inst_ack_i = 1'b0;
    inst_data_i = 32'hDEAD_BEEF;
    tick();
    check("st3_valid", {31'h0, inst_valid_o}, 32'h0);
    tick();
    check("st4_valid", {31'h0, inst_valid_o}, 32'h0);
    stall_req_ex = 1'b0;
    #1;
    check("st_release", {26'h0, stall}, 32'h0);
    tick();
    check("st_deliver_valid", {31'h0, inst_valid_o}, 32'h1);
    check("st_deliver_inst", inst_o, 32'hC000_0100);
    check("st_deliver_pc", pc, 32'h104);
    check("st_deliver_req", {31'h0, inst_req_o}, 32'h1);

    // Pending target overwritten by a second branch, then wrap.
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h200;
    tick();
    branch_target_address_i = 32'hFFFF_FFFC;
    tick();
    check("ovw_pc", pc, 32'h104);
    branch_flag_i = 1'b0;
    branch_target_address_i = 32'h0;
    inst_ack_i = 1'b1;
    inst_data_i = 32'hD000_0104;
    tick();
    check("ovw_target", pc, 32'hFFFF_FFFC);
    inst_data_i = 32'hD000_FFFC;
    tick();
    check("wrap_pc", pc, 32'h0);
    check("wrap_inst", inst_o, 32'hD000_FFFC);

    // Branch during ID stall is ignored.
    inst_ack_i = 1'b0;
    stall_req_id = 1'b1;
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h300;
    tick();
    stall_req_id = 1'b0;
    branch_flag_i = 1'b0;
    branch_target_address_i = 32'h0;
    inst_ack_i = 1'b1;
    inst_data_i = 32'hE000_0000;
    tick();
    check("idstall_br_ignored", pc, 32'h4);

`ifdef FETCH_EXCP_EN
    // Move to pc 0x40.
    inst_ack_i = 1'b0;
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h40;
    tick();
    branch_flag_i = 1'b0;
    inst_ack_i = 1'b1;
    tick();
    check("ex_pre_pc", pc, 32'h40);

    // Exception with request outstanding -> DRAIN.
    inst_ack_i = 1'b0;
    excp_flag_i = 1'b1;
    tick();
    check("ex_flush", {31'h0, flush}, 32'h1);
    check("ex_epc", excp_epc_o, 32'h40);
    check("ex_req_kept", {31'h0, inst_req_o}, 32'h1);
    check("ex_valid", {31'h0, inst_valid_o}, 32'h0);
    excp_flag_i = 1'b0;
    tick();
    check("ex_flush_pulse", {31'h0, flush}, 32'h0);
    inst_ack_i = 1'b1;
    inst_data_i = 32'hBAD0_BAD0;
    tick();
    check("ex_discard", {31'h0, inst_valid_o}, 32'h0);
    check("ex_vector", pc, 32'h20);
    inst_ack_i = 1'b0;
    tick();
    check("ex_fetch_req", {31'h0, inst_req_o}, 32'h1);

    // Reset mid-DRAIN.
    excp_flag_i = 1'b1;
    tick();
    excp_flag_i = 1'b0;
    rst = 1'b0;
    inst_ack_i = 1'b1;
    tick();
    check("exrst_pc", pc, 32'h0);
    check("exrst_ce", {31'h0, ce}, 32'h0);
    check("exrst_req", {31'h0, inst_req_o}, 32'h0);
    check("exrst_epc", excp_epc_o, 32'h0);
    check("exrst_flush", {31'h0, flush}, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer that owns the program counter.
- Drives a request/acknowledge handshake to instruction memory (variable wait states) and applies branch redirects with MIPS delay-slot semantics.
- Generates the pipeline stall vector from ID/EX stall requests and delivers fetched instructions to the IF/ID boundary.
- Sits between the ID/EX stages and the instruction memory port.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- EXCP_VECTOR, 32'h0000_0020, redirect address on exception (used only with FETCH_EXCP_EN).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset; synchronous, active-low (rst==0 resets on the clock edge)
- stall_req_id  in  1  ID stage requests a stall
- stall_req_ex  in  1  EX stage requests a stall (multi-cycle op)
- branch_flag_i  in  1  ID resolved a taken branch/jump
- branch_target_address_i  in  32  branch target
- inst_ack_i  in  1  imem returns inst_data_i this cycle for current pc
- inst_data_i  in  32  imem read data
- pc  out  32  current fetch address
- ce  out  1  imem chip enable
- inst_req_o  out  1  fetch request
- inst_o  out  32  instruction to IF/ID
- inst_valid_o  out  1  inst_o valid this cycle
- stall  out  6  {wb,mem,ex,id,if,pc} stall vector
- flush  out  1  pipeline flush pulse
- excp_flag_i  in  1  exception taken (FETCH_EXCP_EN only)
- excp_epc_o  out  32  abandoned fetch pc (FETCH_EXCP_EN only)

Behaviour:
- Reset (rst==0 at edge): state IDLE; pc=RESET_PC; ce=0; inst_req_o=0; inst_o=0; inst_valid_o=0; flush=0; excp_epc_o=0; pending-redirect flag cleared.
  - Reset mid-transaction aborts immediately.
  - An inst_ack_i in the reset cycle is ignored.
- stall is combinational, zero latency:
  - stall_req_ex=1 -> 6'b001111.
  - Else stall_req_id=1 -> 6'b000111.
  - Else 6'b000000.
  - IF-stalled means stall[1]=1.
- All other outputs are registered.
- States: IDLE, FETCH, HOLD, DRAIN (DRAIN exists only with FETCH_EXCP_EN).
- IDLE: on the first cycle with rst==1, set ce=1 and inst_req_o=1 and go to FETCH; pc stays RESET_PC.
- FETCH:
  - inst_req_o=1.
  - pc and inst_req_o must stay stable until inst_ack_i; a request is never withdrawn.
  - On ack with IF not stalled: inst_o<=inst_data_i, inst_valid_o<=1 next cycle.
    - Next pc is the pending target (flag cleared) if pending; else branch_target_address_i if branch_flag_i=1 this cycle; else pc+4.
    - Stay in FETCH.
  - On ack while IF stalled: capture data in a hold register, set inst_req_o<=0, go to HOLD.
  - No ack: inst_valid_o<=0.
- HOLD:
  - pc held, inst_valid_o=0.
  - When IF is unstalled: inst_o<=held data, inst_valid_o<=1, pc updates by the FETCH rule, inst_req_o<=1, go to FETCH.
- Branch handling:
  - branch_flag_i is sampled only when ID is not stalled (stall[2]=0).
  - In FETCH without ack, or in HOLD, the target is latched as pending.
  - The in-flight instruction is the delay slot and is always delivered, never flushed.
  - A second branch while one is pending overwrites the pending target.
- inst_valid_o is a one-cycle pulse per delivered instruction; at most one instruction is in flight.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- Branch targets are used unmodified.

Optional Feature:
- Macro: FETCH_EXCP_EN.
- Defined:
  - excp_flag_i overrides stall, branch and pending.
  - Next cycle: flush=1 for exactly one cycle, excp_epc_o<=the pc being fetched or next to fetch, pending cleared, inst_valid_o=0.
  - If a request is outstanding without ack (FETCH), go to DRAIN: keep request stable, discard the acked data, then pc<=EXCP_VECTOR and go to FETCH.
  - Otherwise pc<=EXCP_VECTOR and go directly to FETCH (HOLD data is discarded).
- Undefined: excp_flag_i and excp_epc_o ports are absent, flush is tied 0, DRAIN does not exist.

Test Plan:
- Reset release, inst_ack_i always 1 -> ce rises 1 cycle after rst=1; pc sequence 0x0,0x4,0x8; inst_valid_o pulses each cycle with matching data.
- inst_ack_i delayed 3 cycles -> pc and inst_req_o stable for those 3 cycles; exactly one inst_valid_o pulse; pc then advances by 4.
- branch_flag_i=1 with target 0x100 while fetching pc=0x20 with no ack -> delay slot 0x20 is delivered; next fetch pc=0x100; flush stays 0.
- stall_req_ex=1 for 4 cycles with ack arriving during stall -> stall=6'b001111 immediately; no inst_valid_o during stall; held instruction delivered the cycle after release; pc advances by 4.
- pc=32'hFFFF_FFFC acked -> next pc=0x0.
- (FETCH_EXCP_EN) excp_flag_i at pc=0x40 with request outstanding -> flush pulses 1 cycle; excp_epc_o=0x40; late ack data discarded; next fetch pc=0x20; rst=0 mid-DRAIN returns to IDLE with pc=0x0.
